// File: rtl/man_pkg.sv
// Shared state encoding and line-code helpers for the Manchester frame transmitter.
package man_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic CONV_IEEE   = 1'b0;
    localparam logic CONV_THOMAS = 1'b1;

    // Level driven during the first half of a bit; the second half is its inverse.
    function automatic logic first_half(input logic bit_val, input logic conv);
        return (conv == CONV_THOMAS) ? bit_val : ~bit_val;
    endfunction

endpackage

// File: rtl/man_halfbit_tick.sv
// Half-bit divider: counts 0..HALF_BIT_DIV-1 and flags the wrap cycle as a tick.
module man_halfbit_tick #(
    parameter int HALF_BIT_DIV = 4
) (
    input  logic clk,
    input  logic in_rst_n,
    input  logic in_clear,
    output logic out_tick,
    output logic out_tick_next
);

    localparam int CW = (HALF_BIT_DIV > 1) ? $clog2(HALF_BIT_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_BIT_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    always_comb begin
        if (in_clear) begin
            w_cnt_next = '0;
        end else if (r_cnt == CNT_LAST) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign out_tick      = (r_cnt == CNT_LAST);
    // Lets the parent register a pulse that must line up with the coming tick.
    assign out_tick_next = (w_cnt_next == CNT_LAST);

endmodule

// File: rtl/man_enc_tx.sv
// Manchester frame transmitter: optional start bit, DATA_W data bits, one stop period.
//   state    | meaning
//   ST_IDLE  | line at IDLE_LEVEL, ready for a word when enabled
//   ST_START | sending the encoded '1' start bit
//   ST_DATA  | sending data bits from the shift register
//   ST_STOP  | one bit period at IDLE_LEVEL before returning to idle
module man_enc_tx
    import man_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int HALF_BIT_DIV = 4,
    parameter bit CONVENTION   = 1'b0,
    parameter bit START_BIT    = 1'b1,
    parameter bit MSB_FIRST    = 1'b1,
    parameter bit IDLE_LEVEL   = 1'b0
) (
    input  logic              clk,
    input  logic              in_rst_n,
    input  logic              in_enable,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              out_ready,
    output logic              out_data,
    output logic              out_busy,
    output logic              out_done,
    output logic              out_abort
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    state_t              r_state;
    logic                r_half;
    logic [BW-1:0]       r_bit_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_out_data;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_abort;

    state_t              w_state_next;
    logic                w_half_next;
    logic [BW-1:0]       w_bit_cnt_next;
    logic [DATA_W-1:0]   w_shift_next;
    logic                w_out_next;
    logic                w_done_next;
    logic                w_accept;
    logic                w_abort;
    logic                w_clear;
    logic                w_tick;
    logic                w_tick_next;
    logic [DATA_W-1:0]   w_shift_adv;

    function automatic logic lead_bit(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? v[DATA_W-1] : v[0];
    endfunction

    // r_ready already implies ST_IDLE; in_enable is re-checked so a same-cycle drop blocks accept.
    assign w_accept    = r_ready & in_valid & in_enable;
    assign w_abort     = (r_state != ST_IDLE) & ~in_enable;
    assign w_clear     = (r_state == ST_IDLE) | w_abort;
    assign w_shift_adv = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

    man_halfbit_tick #(
        .HALF_BIT_DIV (HALF_BIT_DIV)
    ) u_tick (
        .clk           (clk),
        .in_rst_n      (in_rst_n),
        .in_clear      (w_clear),
        .out_tick      (w_tick),
        .out_tick_next (w_tick_next)
    );

    always_comb begin
        w_state_next   = r_state;
        w_half_next    = r_half;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_out_next     = r_out_data;

        case (r_state)
            ST_IDLE: begin
                w_out_next = IDLE_LEVEL;
                if (w_accept) begin
                    w_shift_next   = in_data;
                    w_half_next    = 1'b0;
                    w_bit_cnt_next = '0;
                    if (START_BIT) begin
                        w_state_next = ST_START;
                        w_out_next   = first_half(1'b1, CONVENTION);
                    end else begin
                        w_state_next = ST_DATA;
                        w_out_next   = first_half(lead_bit(in_data), CONVENTION);
                    end
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (!r_half) begin
                        w_half_next = 1'b1;
                        w_out_next  = ~r_out_data;
                    end else begin
                        w_half_next  = 1'b0;
                        w_state_next = ST_DATA;
                        w_out_next   = first_half(lead_bit(r_shift), CONVENTION);
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (!r_half) begin
                        w_half_next = 1'b1;
                        w_out_next  = ~r_out_data;
                    end else begin
                        w_half_next    = 1'b0;
                        w_shift_next   = w_shift_adv;
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_next = ST_STOP;
                            w_out_next   = IDLE_LEVEL;
                        end else begin
                            w_out_next = first_half(lead_bit(w_shift_adv), CONVENTION);
                        end
                    end
                end
            end
            ST_STOP: begin
                w_out_next = IDLE_LEVEL;
                if (w_tick) begin
                    if (!r_half) begin
                        w_half_next = 1'b1;
                    end else begin
                        w_half_next    = 1'b0;
                        w_bit_cnt_next = '0;
                        w_state_next   = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_out_next   = IDLE_LEVEL;
            end
        endcase

        if (w_abort) begin
            w_state_next   = ST_IDLE;
            w_half_next    = 1'b0;
            w_bit_cnt_next = '0;
            w_out_next     = IDLE_LEVEL;
        end

        // Registered done must appear during the final STOP cycle, so look one tick ahead.
        w_done_next = (w_state_next == ST_STOP) & w_half_next & w_tick_next;
    end

    always_ff @(posedge clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state    <= ST_IDLE;
            r_half     <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_out_data <= IDLE_LEVEL;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_half     <= w_half_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_out_data <= w_out_next;
            r_ready    <= (w_state_next == ST_IDLE) & in_enable;
            r_busy     <= (w_state_next != ST_IDLE);
            r_done     <= w_done_next;
            r_abort    <= w_abort;
        end
    end

    assign out_ready = r_ready;
    assign out_data  = r_out_data;
    assign out_busy  = r_busy;
    assign out_done  = r_done;
    assign out_abort = r_abort;

endmodule

// File: tb/tb_man_enc_tx.sv
// Directed bench for man_enc_tx: three configurations driven in parallel from shared controls.
module tb_man_enc_tx;
    import man_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       valid;
    logic [7:0] d_ab;
    logic [7:0] d_c;

    logic rdy_a, dat_a, busy_a, done_a, abort_a;
    logic rdy_b, dat_b, busy_b, done_b, abort_b;
    logic rdy_c, dat_c, busy_c, done_c, abort_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    man_enc_tx #(.DATA_W(8), .HALF_BIT_DIV(2), .CONVENTION(CONV_IEEE), .START_BIT(1'b1),
                 .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .in_rst_n(rst_n), .in_enable(en), .in_data(d_ab), .in_valid(valid),
        .out_ready(rdy_a), .out_data(dat_a), .out_busy(busy_a), .out_done(done_a), .out_abort(abort_a));

    man_enc_tx #(.DATA_W(8), .HALF_BIT_DIV(2), .CONVENTION(CONV_THOMAS), .START_BIT(1'b1),
                 .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .in_rst_n(rst_n), .in_enable(en), .in_data(d_ab), .in_valid(valid),
        .out_ready(rdy_b), .out_data(dat_b), .out_busy(busy_b), .out_done(done_b), .out_abort(abort_b));

    man_enc_tx #(.DATA_W(8), .HALF_BIT_DIV(1), .CONVENTION(CONV_IEEE), .START_BIT(1'b0),
                 .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_c (
        .clk(clk), .in_rst_n(rst_n), .in_enable(en), .in_data(d_c), .in_valid(valid),
        .out_ready(rdy_c), .out_data(dat_c), .out_busy(busy_c), .out_done(done_c), .out_abort(abort_c));

    // Half-bit sequences are written first-half-bit-first (MSB of each field).
    typedef struct {
        logic [7:0]  d_a;
        logic [17:0] hb_a;
        logic [17:0] hb_b;
        logic [7:0]  d_c;
        logic [15:0] hb_c;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got %b expected %b at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rdy_a && rdy_c) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_ready timeout at %0t", $time);
        end
    endtask

    task automatic run_frame(input int vi);
        vec_t v;
        logic ea, eb, ec;
        v = vecs[vi];
        wait_ready();
        d_ab  = v.d_a;
        d_c   = v.d_c;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        d_ab  = ~d_ab;
        d_c   = ~d_c;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            ea = (k <= 36) ? v.hb_a[17 - (k - 1) / 2] : 1'b0;
            eb = (k <= 36) ? v.hb_b[17 - (k - 1) / 2] : 1'b0;
            ec = (k <= 16) ? v.hb_c[16 - k] : 1'b0;
            chk("data_a", k, dat_a, ea);
            chk("data_b", k, dat_b, eb);
            chk("data_c", k, dat_c, ec);
            chk("done_a", k, done_a, k == 40);
            chk("done_b", k, done_b, k == 40);
            chk("ready_a", k, rdy_a, k == 41);
            chk("busy_a", k, busy_a, k <= 40);
            chk("abort_a", k, abort_a, 1'b0);
            chk("done_c", k, done_c, k == 18);
            chk("ready_c", k, rdy_c, k >= 19);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   nd;
        int   j;
        logic [17:0] hb;
        vecs[0] = '{8'hA5, 18'b01_01_10_01_10_10_01_10_01, 18'b10_10_01_10_01_01_10_01_10,
                    8'h01, 16'b01_10_10_10_10_10_10_10};
        vecs[1] = '{8'h00, 18'b01_10_10_10_10_10_10_10_10, 18'b10_01_01_01_01_01_01_01_01,
                    8'h80, 16'b10_10_10_10_10_10_10_01};
        vecs[2] = '{8'hFF, 18'b01_01_01_01_01_01_01_01_01, 18'b10_10_10_10_10_10_10_10_10,
                    8'hC3, 16'b01_01_10_10_10_10_01_01};
        vecs[3] = '{8'h3C, 18'b01_10_10_01_01_01_01_10_10, 18'b10_01_01_10_10_10_10_01_01,
                    8'h5A, 16'b10_01_10_01_01_10_01_10};

        rst_n = 1'b0;
        en    = 1'b1;
        valid = 1'b0;
        d_ab  = '0;
        d_c   = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready_a", 0, rdy_a, 1'b0);
        chk("rst_ready_c", 0, rdy_c, 1'b0);
        chk("rst_data_a", 0, dat_a, 1'b0);
        chk("rst_busy_a", 0, busy_a, 1'b0);
        chk("rst_done_a", 0, done_a, 1'b0);
        chk("rst_abort_a", 0, abort_a, 1'b0);
        #1 rst_n = 1'b1;

        for (int vi = 0; vi < 4; vi++) run_frame(vi);

        // Back-to-back: valid held high, second word must go out with only the STOP gap.
        wait_ready();
        d_ab  = 8'h00;
        valid = 1'b1;
        @(posedge clk);
        #1 d_ab = 8'hFF;
        for (int k = 1; k <= 82; k++) begin
            @(negedge clk);
            j  = (k <= 41) ? k : k - 41;
            hb = (k <= 41) ? vecs[1].hb_a : vecs[2].hb_a;
            chk("b2b_data_a", k, dat_a, (j <= 36) ? hb[17 - (j - 1) / 2] : 1'b0);
            chk("b2b_done_a", k, done_a, j == 40);
            chk("b2b_ready_a", k, rdy_a, j == 41);
            chk("b2b_busy_a", k, busy_a, j <= 40);
            if (k == 42) valid = 1'b0;
        end

        // Abort: drop enable so it is sampled on the edge ending cycle 10.
        wait_ready();
        d_ab  = 8'hA5;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_pre_data_a", 10, dat_a, 1'b1);
        en = 1'b0;
        @(negedge clk);
        chk("abort_data_a", 11, dat_a, 1'b0);
        chk("abort_pulse_a", 11, abort_a, 1'b1);
        chk("abort_done_a", 11, done_a, 1'b0);
        chk("abort_busy_a", 11, busy_a, 1'b0);
        chk("abort_ready_a", 11, rdy_a, 1'b0);
        @(negedge clk);
        chk("abort_pulse_end_a", 12, abort_a, 1'b0);
        chk("abort_ready_dis_a", 12, rdy_a, 1'b0);
        en = 1'b1;
        @(negedge clk);
        chk("reenable_ready_a", 13, rdy_a, 1'b1);
        nd = 0;
        for (int k = 14; k <= 50; k++) begin
            @(negedge clk);
            if (done_a) nd++;
        end
        chk("abort_no_done_a", 50, nd != 0, 1'b0);

        // Enable low in IDLE with valid high: no accept, no pulse.
        wait_ready();
        en    = 1'b0;
        valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("idle_dis_busy_a", k, busy_a, 1'b0);
            chk("idle_dis_ready_a", k, rdy_a, 1'b0);
            chk("idle_dis_abort_a", k, abort_a, 1'b0);
        end
        valid = 1'b0;
        en    = 1'b1;

        // Asynchronous reset in the middle of DATA.
        wait_ready();
        d_ab  = 8'hA5;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("mid_data_a", 15, dat_a, 1'b1);
        chk("mid_busy_a", 15, busy_a, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_data_a", 15, dat_a, 1'b0);
        chk("async_rst_busy_a", 15, busy_a, 1'b0);
        chk("async_rst_ready_a", 15, rdy_a, 1'b0);
        chk("async_rst_done_a", 15, done_a, 1'b0);
        chk("async_rst_abort_a", 15, abort_a, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        run_frame(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
